req_ack_responder: RTL and testbench

Responder side of the single-bit req/ack handshake. It accepts a level request on `req` and returns `ack` a fixed, parameterised number of clock edges later. It counts completed transactions and flags requests that are withdrawn early. It sits directly downstream of the requester and drives the `ack` that the handshake assertions (`req |-> ack`, `req |-> ##LATENCY ack`) check.

---
 rtl/req_ack_responder_if.sv | 28 ++
 rtl/req_ack_responder.sv | 125 ++++++++++++
 tb/tb_req_ack_responder.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/req_ack_responder_if.sv
// Single-bit req/ack handshake bundle with responder status.
// The requester drives req. The responder returns ack and reports
// busy, the completed-transaction count and the sticky drop flag.
interface req_ack_responder_if #(
   parameter int CNT_W = 8
);
   logic             req;
   logic             ack;
   logic             busy;
   logic [CNT_W-1:0] req_cnt;
   logic             drop_err;

   modport master (
      output req,
      input  ack,
      input  busy,
      input  req_cnt,
      input  drop_err
   );

   modport slave (
      input  req,
      output ack,
      output busy,
      output req_cnt,
      output drop_err
   );
endinterface

// File: rtl/req_ack_responder.sv
// Responder side of the req/ack handshake.
// LATENCY = 0: ack is a combinational copy of req, masked by reset.
// LATENCY >= 1: an IDLE/WAIT/ACK state machine returns a registered
// one-cycle ack LATENCY edges after acceptance. In this mode the
// machine counts completed transactions and flags early withdrawal.
module req_ack_responder #(
   parameter int LATENCY = 1,
   parameter int CNT_W   = 8
) (
   input logic              clk,
   input logic              rst,
   req_ack_responder_if.slave bus
);

   generate
      if (LATENCY == 0) begin : g_passthru
         logic [CNT_W-1:0] cnt_q;
         logic [CNT_W-1:0] cnt_d;

         // Every edge that sees req high completes a transaction.
         always_comb begin
            cnt_d = cnt_q;
            if (bus.req) begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         // Counter register; reset takes priority over a concurrent req.
         always_ff @(posedge clk) begin
            if (rst) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end

         assign bus.ack      = bus.req & ~rst;
         assign bus.busy     = 1'b0;
         assign bus.drop_err = 1'b0;
         assign bus.req_cnt  = cnt_q;
      end else begin : g_fsm
         typedef enum logic [1:0] {
            S_IDLE = 2'd0,
            S_WAIT = 2'd1,
            S_ACK  = 2'd2
         } state_t;

         // Edges spent in WAIT are wcnt load value + 1. The load applies only when LATENCY >= 2.
         localparam logic [3:0] WCNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

         state_t           state_q;
         state_t           state_d;
         logic [3:0]       wcnt_q;
         logic [3:0]       wcnt_d;
         logic [CNT_W-1:0] cnt_q;
         logic [CNT_W-1:0] cnt_d;
         logic             drop_q;
         logic             drop_d;

         // Next-state, wait counter, completion counter and drop flag.
         always_comb begin
            state_d = state_q;
            wcnt_d  = wcnt_q;
            cnt_d   = cnt_q;
            drop_d  = drop_q;
            case (state_q)
               S_IDLE: begin
                  if (bus.req) begin
                     if (LATENCY == 1) begin
                        state_d = S_ACK;
                     end else begin
                        state_d = S_WAIT;
                        wcnt_d  = WCNT_LOAD;
                     end
                  end
               end
               S_WAIT: begin
                  if (!bus.req) begin
                     drop_d  = 1'b1;
                     state_d = S_IDLE;
                  end else if (wcnt_q == 4'd0) begin
                     state_d = S_ACK;
                  end else begin
                     wcnt_d = wcnt_q - 4'd1;
                  end
               end
               S_ACK: begin
                  // The req sampled here closes the current transaction.
                  // It is never taken as a new request.
                  state_d = S_IDLE;
                  if (bus.req) begin
                     cnt_d = cnt_q + 1'b1;
                  end else begin
                     drop_d = 1'b1;
                  end
               end
               default: begin
                  state_d = S_IDLE;
               end
            endcase
         end

         // State registers. A reset mid-transaction abandons it silently.
         always_ff @(posedge clk) begin
            if (rst) begin
               state_q <= S_IDLE;
               wcnt_q  <= 4'd0;
               cnt_q   <= '0;
               drop_q  <= 1'b0;
            end else begin
               state_q <= state_d;
               wcnt_q  <= wcnt_d;
               cnt_q   <= cnt_d;
               drop_q  <= drop_d;
            end
         end

         assign bus.ack      = (state_q == S_ACK);
         assign bus.busy     = (state_q != S_IDLE);
         assign bus.req_cnt  = cnt_q;
         assign bus.drop_err = drop_q;
      end
   endgenerate

endmodule

// File: tb/tb_req_ack_responder.sv
// Scoreboard bench for req_ack_responder.
// It instantiates five responders: LATENCY 0..4, with CNT_W = 2 on the
// LATENCY = 1 instance and CNT_W = 8 elsewhere.
// Stimulus pushes the expected ack edges and status snapshots into queues.
// The monitor pops and compares them on the falling edge.
module tb_req_ack_responder;
   localparam int N = 5;

   typedef struct {
      int   dut;
      int   at;
      logic busy;
      int   cnt;
      logic err;
   } st_t;

   logic         clk;
   logic [N-1:0] rst_v;
   logic [N-1:0] req_v;
   logic [N-1:0] ack_v;
   logic [N-1:0] busy_v;
   logic [N-1:0] err_v;
   logic [7:0]   cnt_v [N];
   int           cyc;
   bit           done;
   int           n_cmp;
   int           n_err;

   int  exp_ack [N][$];
   st_t st_q[$];

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_dut
         localparam int CW = (gi == 1) ? 2 : 8;
         req_ack_responder_if #(.CNT_W(CW)) bus ();
         req_ack_responder #(.LATENCY(gi), .CNT_W(CW)) dut (
            .clk (clk),
            .rst (rst_v[gi]),
            .bus (bus)
         );
         assign bus.req    = req_v[gi];
         assign ack_v[gi]  = bus.ack;
         assign busy_v[gi] = bus.busy;
         assign err_v[gi]  = bus.drop_err;
         assign cnt_v[gi]  = 8'(bus.req_cnt);
      end
   endgenerate

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count rising edges. After edge k, cyc == k.
   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Expect ack to be sampled high at edge (cyc + off).
   task automatic expect_ack(input int d, input int off);
      exp_ack[d].push_back(cyc + off);
   endtask

   // Expect a status snapshot during cycle (cyc + off).
   task automatic expect_st(input int d, input int off, input logic b,
                            input int c, input logic e);
      st_t s;
      s.dut  = d;
      s.at   = cyc + off;
      s.busy = b;
      s.cnt  = c;
      s.err  = e;
      st_q.push_back(s);
   endtask

   // Stimulus: directed vectors with hand-computed expectations.
   initial begin
      done  = 1'b0;
      rst_v = '1;
      req_v = '1;
      // Reset held for three edges with req high everywhere.
      for (int d = 0; d < N; d++) begin
         for (int c = 1; c <= 3; c++) begin
            expect_st(d, c, 1'b0, 0, 1'b0);
         end
      end
      tick(3);
      rst_v = '0;
      req_v = '0;
      tick(1);

      // LATENCY 0: req toggles 1,0,1,0,1,0 and ack follows in the same cycle.
      for (int i = 0; i < 6; i++) begin
         req_v[0] = (i % 2 == 0);
         if (i % 2 == 0) expect_ack(0, 1);
         tick(1);
      end
      req_v[0] = 1'b0;
      expect_st(0, 0, 1'b0, 3, 1'b0);
      tick(1);

      // LATENCY 3: single transaction with req held through the ack edge.
      req_v[3] = 1'b1;
      expect_st(3, 0, 1'b0, 0, 1'b0);
      expect_st(3, 1, 1'b1, 0, 1'b0);
      expect_st(3, 2, 1'b1, 0, 1'b0);
      expect_st(3, 3, 1'b1, 0, 1'b0);
      expect_st(3, 4, 1'b0, 1, 1'b0);
      expect_ack(3, 4);
      tick(4);
      req_v[3] = 1'b0;
      tick(1);

      // LATENCY 3: req withdrawn at the ACK-state edge. Ack still pulses,
      // drop_err is set and the counter holds.
      req_v[3] = 1'b1;
      expect_ack(3, 4);
      expect_st(3, 4, 1'b0, 1, 1'b1);
      tick(3);
      req_v[3] = 1'b0;
      tick(2);

      // LATENCY 2: req dropped at E0+1, then a good transaction follows.
      req_v[2] = 1'b1;
      expect_st(2, 1, 1'b1, 0, 1'b0);
      expect_st(2, 2, 1'b0, 0, 1'b1);
      tick(1);
      req_v[2] = 1'b0;
      tick(1);
      req_v[2] = 1'b1;
      expect_ack(2, 3);
      expect_st(2, 3, 1'b0, 1, 1'b1);
      tick(3);
      req_v[2] = 1'b0;
      tick(1);

      // LATENCY 1, CNT_W 2: req held for 20 edges gives 10 acks. The count wraps 3 -> 0.
      req_v[1] = 1'b1;
      for (int i = 1; i <= 10; i++) expect_ack(1, 2 * i);
      expect_st(1, 7,  1'b1, 3, 1'b0);
      expect_st(1, 8,  1'b0, 0, 1'b0);
      expect_st(1, 20, 1'b0, 2, 1'b0);
      tick(20);
      req_v[1] = 1'b0;
      tick(1);

      // LATENCY 4: reset at E0+2 aborts the transaction. The retry
      // is accepted at the edge after reset and acks four edges later.
      req_v[4] = 1'b1;
      expect_st(4, 1, 1'b1, 0, 1'b0);
      expect_st(4, 2, 1'b1, 0, 1'b0);
      expect_st(4, 3, 1'b0, 0, 1'b0);
      expect_st(4, 4, 1'b1, 0, 1'b0);
      expect_st(4, 7, 1'b1, 0, 1'b0);
      expect_st(4, 8, 1'b0, 1, 1'b0);
      expect_ack(4, 8);
      tick(2);
      rst_v[4] = 1'b1;
      tick(1);
      rst_v[4] = 1'b0;
      tick(5);
      req_v[4] = 1'b0;
      tick(2);
      done = 1'b1;
   end

   // Monitor: compares DUT outputs against the queued expectations.
   initial begin
      st_t s;
      n_cmp = 0;
      n_err = 0;
      forever begin
         @(negedge clk);
         if (cyc > 0) begin
            for (int d = 0; d < N; d++) begin
               while (exp_ack[d].size() > 0 && exp_ack[d][0] < cyc + 1) begin
                  n_cmp = n_cmp + 1;
                  n_err = n_err + 1;
                  $display("FAIL ack_missing dut%0d: ack=0 at edge %0d, required 1",
                           d, exp_ack[d][0]);
                  void'(exp_ack[d].pop_front());
               end
               if (ack_v[d] !== 1'b0) begin
                  n_cmp = n_cmp + 1;
                  if (exp_ack[d].size() > 0 && exp_ack[d][0] == cyc + 1) begin
                     $display("ack dut%0d sampled at edge %0d as expected", d, cyc + 1);
                     void'(exp_ack[d].pop_front());
                  end else begin
                     n_err = n_err + 1;
                     $display("FAIL ack_unexpected dut%0d: ack=%b at edge %0d, required 0",
                              d, ack_v[d], cyc + 1);
                  end
               end
            end
            for (int i = 0; i < st_q.size(); ) begin
               if (st_q[i].at == cyc) begin
                  s = st_q[i];
                  st_q.delete(i);
                  n_cmp = n_cmp + 1;
                  if (busy_v[s.dut] !== s.busy || 32'(cnt_v[s.dut]) !== s.cnt ||
                      err_v[s.dut] !== s.err) begin
                     n_err = n_err + 1;
                     $display("FAIL status dut%0d cyc%0d: busy=%b cnt=%0d err=%b, required busy=%b cnt=%0d err=%b",
                              s.dut, cyc, busy_v[s.dut], cnt_v[s.dut], err_v[s.dut],
                              s.busy, s.cnt, s.err);
                  end
               end else begin
                  i++;
               end
            end
         end
         if (done || cyc > 2000) begin
            if (!done) begin
               n_cmp = n_cmp + 1;
               n_err = n_err + 1;
               $display("FAIL timeout: cycle %0d reached, required completion by 2000", cyc);
            end
            for (int d = 0; d < N; d++) begin
               n_cmp = n_cmp + 1;
               if (exp_ack[d].size() != 0) begin
                  n_err = n_err + 1;
                  $display("FAIL ack_leftover dut%0d: %0d acks outstanding, required 0",
                           d, exp_ack[d].size());
               end
            end
            n_cmp = n_cmp + 1;
            if (st_q.size() != 0) begin
               n_err = n_err + 1;
               $display("FAIL status_leftover: %0d checks outstanding, required 0", st_q.size());
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
            $finish;
         end
      end
   end

endmodule
